io_button_regs: RTL

Memory-mapped button register block sitting directly downstream of the I/O address decoder in the single-cycle processor. Synchronizes and debounces the board push-buttons and latches each press into a sticky pending flag. The CPU reads a flag through the decoder's button-region enable and 2-bit button select, and the flag clears on read or by explicit write. Read data feeds the processor's load-data mux alongside data memory.

---
 rtl/io_button_regs_pkg.sv | 26 ++
 rtl/io_button_regs_if.sv | 38 +++
 rtl/btn_debounce.sv | 63 ++++++
 rtl/io_button_regs.sv | 74 +++++++
 4 files changed

// File: rtl/io_button_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared widths, the button index type and named button indices
//            for the I/O address decoder and the button register block.
// Revision : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int NUM_BTN    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int BTN_IDX_W  = 2;

    typedef logic [BTN_IDX_W-1:0] btn_idx_t;

    localparam btn_idx_t BTN_KEY0 = 2'd0;
    localparam btn_idx_t BTN_KEY1 = 2'd1;
    localparam btn_idx_t BTN_KEY2 = 2'd2;
    localparam btn_idx_t BTN_KEY3 = 2'd3;

    function automatic logic [NUM_BTN-1:0] idx_onehot(input btn_idx_t idx);
        return {{(NUM_BTN-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_button_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : io_button_regs_if
// Purpose  : Decoder/CPU side bus into the button register block.
// Revision : 1.0 - initial release
// ============================================================================
interface io_button_regs_if #(
    parameter int DATA_WIDTH = io_pkg::DATA_WIDTH
);
    import io_pkg::*;

    logic                  btn_enb;
    btn_idx_t              btn_selecc;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output btn_enb,
        output btn_selecc,
        output mem_read,
        output mem_write,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  btn_enb,
        input  btn_selecc,
        input  mem_read,
        input  mem_write,
        input  wr_data,
        output rd_data
    );

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : One button: 2-FF synchronizer, polarity normalization, debounce
//            counter with stable level, and a single-cycle press pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic btn_raw,
    output logic      press
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             level;
    logic             sync_meta;
    logic             sync_q;
    logic             stable;
    logic [CNT_W-1:0] count;
    logic             differs;
    logic             at_limit;

    assign level = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= level;
            sync_q    <= sync_meta;
        end
    end

    assign differs  = sync_q ^ stable;
    assign at_limit = (count == CNT_LAST);

    // The counter is cleared on every flip, so it saturates at CNT_LAST and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (!differs) begin
            count  <= '0;
        end else if (at_limit) begin
            stable <= ~stable;
            count  <= '0;
        end else begin
            count  <= count + 1'b1;
        end
    end

    // Combinational so the pending flag captures it on the same edge stable rises.
    assign press = differs & at_limit & ~stable;

endmodule
`default_nettype wire

// File: rtl/io_button_regs.sv
`default_nettype none
// ============================================================================
// Module   : io_button_regs
// Purpose  : Debounced push-buttons latched into sticky pending flags,
//            readable and clearable through the decoder's button region.
// Revision : 1.0 - initial release
// ============================================================================
module io_button_regs #(
    parameter int NUM_BTN         = io_pkg::NUM_BTN,
    parameter int DATA_WIDTH      = io_pkg::DATA_WIDTH,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter bit CLEAR_ON_READ   = 1'b1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [NUM_BTN-1:0] btn_raw,
    io_button_regs_if.slave         bus,
    output logic [NUM_BTN-1:0]      pending_vec
);

    import io_pkg::*;

    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] sel_hit;
    logic [NUM_BTN-1:0] clr;
    logic               access_clr;
    logic               unused_wr_bits;

    genvar i;
    generate
        for (i = 0; i < NUM_BTN; i++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
            ) u_debounce (
                .clk     (clk),
                .rst     (rst),
                .btn_raw (btn_raw[i]),
                .press   (press[i])
            );
        end
    endgenerate

    // A read and a write to the same flag on one edge collapse into a single clear.
    assign access_clr = bus.btn_enb
                      & ((bus.mem_read & CLEAR_ON_READ) | (bus.mem_write & bus.wr_data[0]));
    assign sel_hit    = idx_onehot(bus.btn_selecc);
    assign clr        = sel_hit & {NUM_BTN{access_clr}};

    // Only bit 0 of the store data carries meaning.
    assign unused_wr_bits = ^bus.wr_data[DATA_WIDTH-1:1];

    // Set has priority over clear so a press coinciding with a clear is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | press;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        if (bus.btn_enb) begin
            bus.rd_data[0] = pending[bus.btn_selecc];
        end
    end

    assign pending_vec = pending;

endmodule
`default_nettype wire
